// File: rtl/buffer_pkg.sv
// Shared defaults and helpers for the elastic delay buffer.
// The entry filter is compiled in only when BUFFER_FILTER_EN is defined.
package buffer_pkg;

  localparam int BUF_WIDTH_DEF = 2;
  localparam int BUF_DEPTH_DEF = 4;
  localparam logic [1:0] BUF_FILTER_MATCH_DEF = 2'b01;
  localparam logic [1:0] BUF_FILTER_REPL_DEF  = 2'b00;

  // Widest word the filter helper handles; callers zero-extend into it.
  localparam int BUF_MAX_WIDTH = 64;

  // Replace one code with another; every other code passes through.
  function automatic logic [BUF_MAX_WIDTH-1:0] buf_filter(
    input logic [BUF_MAX_WIDTH-1:0] data,
    input logic [BUF_MAX_WIDTH-1:0] match,
    input logic [BUF_MAX_WIDTH-1:0] repl
  );
    return (data == match) ? repl : data;
  endfunction

endpackage

// File: rtl/buffer_stage.sv
// One register stage of the elastic buffer: a valid flag plus its data word.
// Data only moves when a valid word is loaded, so an empty stage keeps its
// old contents and a flush clears validity without touching data.
module buffer_stage
  import buffer_pkg::*;
#(
  parameter int WIDTH = BUF_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Valid/data register pair; flush outranks a load in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_buffer.sv
// Elastic delay line of DEPTH stages with valid/ready on both sides.
// Empty stages always accept, so bubbles collapse behind a stalled output.
// Optional entry filter enabled by defining BUFFER_FILTER_EN.
module elastic_buffer
  import buffer_pkg::*;
#(
  parameter int               WIDTH        = BUF_WIDTH_DEF,
  parameter int               DEPTH        = BUF_DEPTH_DEF,
  parameter logic [WIDTH-1:0] FILTER_MATCH = WIDTH'(BUF_FILTER_MATCH_DEF),
  parameter logic [WIDTH-1:0] FILTER_REPL  = WIDTH'(BUF_FILTER_REPL_DEF)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

`ifdef BUFFER_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            move;
  logic [WIDTH-1:0]            filtered;
  logic [WIDTH-1:0]            entry_data;
  logic                        in_xfer;
  logic                        out_xfer;

  assign filtered = WIDTH'(buf_filter(BUF_MAX_WIDTH'(in_data),
                                      BUF_MAX_WIDTH'(FILTER_MATCH),
                                      BUF_MAX_WIDTH'(FILTER_REPL)));
  assign entry_data = FILTER_EN ? filtered : in_data;

  // Advance chain, rippling from the output stage back to the input stage.
  always_comb begin
    logic chain;
    move  = '0;
    chain = !valid_q[DEPTH-1] | out_ready;
    move[DEPTH-1] = chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain   = !valid_q[i] | chain;
      move[i] = chain;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      buffer_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .load     (move[0]),
        .up_valid (in_valid),
        .up_data  (entry_data),
        .valid    (valid_q[0]),
        .data     (data_q[0])
      );
    end else begin : g_body
      buffer_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .load     (move[g]),
        .up_valid (valid_q[g-1]),
        .up_data  (data_q[g-1]),
        .valid    (valid_q[g]),
        .data     (data_q[g])
      );
    end
  end

  assign in_ready  = move[0] & !flush;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy counter tracking transfers on both sides; flush empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer (WIDTH=2, DEPTH=4).
// Expected words follow BUFFER_FILTER_EN the same way the design does.
module tb_elastic_buffer;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

`ifdef BUFFER_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
    bit               strict;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   strict_lat = 1'b0;

  elastic_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference for the entry filter: code 1 becomes code 0 when enabled.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d);
    if (FILT && d == 2'b01) return 2'b00;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Monitor: records accepted words and compares every delivered word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out: got word %0d, required none", out_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("out_data", 32'(out_data), 32'(e.data));
            if (e.strict) checkOutput("latency", 32'(cyc - e.cyc), 32'(DEPTH));
          end
        end
        if (in_valid && in_ready) begin
          sb_q.push_back('{model(in_data), cyc, strict_lat});
        end
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic drain();
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("drain_count", 32'(count), 0);
    checkOutput("drain_sb_empty", 32'(sb_q.size()), 0);
  endtask

  initial begin
    // Reset state.
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Streaming back-to-back with strict latency.
    strict_lat = 1'b1;
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    strict_lat = 1'b0;
    drain();

    // Backpressure: six offers into a stalled buffer.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_full_in_ready", 32'(in_ready), 0);
    checkOutput("bp_full_count", 32'(count), 4);
    checkOutput("bp_full_out_valid", 32'(out_valid), 1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("bp_pass_in_ready", 32'(in_ready), 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_pass_count", 32'(count), 4);
    drain();

    // Bubble collapse behind a stalled output.
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bub_count", 32'(count), 2);
    checkOutput("bub_in_ready", 32'(in_ready), 1);
    checkOutput("bub_out_valid", 32'(out_valid), 1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bub_adjacent", 32'(out_valid), 1);
    checkOutput("bub_after_count", 32'(count), 1);
    drain();

    // Flush with an input offered in the same cycle.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_pre_count", 32'(count), 3);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fl_in_ready", 32'(in_ready), 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fl_count", 32'(count), 0);
    checkOutput("fl_out_valid", 32'(out_valid), 0);
    drain();

    // Asynchronous reset with words in flight, then one word after release.
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_out_data", 32'(out_data), 0);
    checkOutput("mid_rst_count", 32'(count), 0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    strict_lat = 1'b1;
    in_valid   = 1'b1;
    in_data    = 2'd3;
    out_ready  = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    strict_lat = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
